// File: rtl/sif_wa_bridge.sv
// SIF XA->WA write bridge: XA writes are queued and drained to WA over valid/ready; XA reads come from a shadow file.
// Optional WA stall timeout enabled by defining SIF_WA_TIMEOUT_EN.
module sif_wa_bridge #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter int NUM_REGS    = 16,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [ADDR_W-1:0]             xa_addr,
  input  logic [DATA_W-1:0]             xa_data_wr,
  input  logic                          xa_wr_s,
  input  logic                          xa_rd_s,
  output logic [DATA_W-1:0]             xa_data_rd,
  output logic                          xa_rd_vld,
  output logic                          xa_busy,
  output logic [ADDR_W-1:0]             wa_addr,
  output logic [DATA_W-1:0]             wa_data_wr,
  output logic                          wa_wr_s,
  input  logic                          wa_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          ovf_err,
  output logic                          to_err,
  output logic                          wa_state_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int IDX_W = $clog2(NUM_REGS);
  localparam int ENT_W = ADDR_W + DATA_W;

  // WA handshake: a transfer happens at a rising edge where wa_wr_s and wa_ready are both high;
  // wa_addr/wa_data_wr hold the head entry unchanged until that edge.
  typedef enum logic {S_IDLE = 1'b0, S_SEND = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [ENT_W-1:0]   mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]   count_q, count_d;
  logic [DATA_W-1:0]  shadow_q [NUM_REGS];
  logic [DATA_W-1:0]  rd_data_q;
  logic               rd_vld_q;
  logic               ovf_q;
  logic               full, push, xfer, drop, pop;
  logic [IDX_W-1:0]   idx;

  assign idx  = xa_addr[IDX_W-1:0];
  // Fullness is judged on the registered count only, so a same-edge pop never rescues a write.
  assign full = (count_q == LVL_W'(FIFO_DEPTH));
  assign push = xa_wr_s & ~full;
  assign xfer = (state_q == S_SEND) & wa_ready;
  assign pop  = xfer | drop;

`ifdef SIF_WA_TIMEOUT_EN
  logic [15:0] stall_q, stall_d;
  logic        to_q;

  assign drop = (state_q == S_SEND) & ~wa_ready & (stall_q == 16'(TIMEOUT_CYC - 1));

  always_comb begin
    stall_d = stall_q + 16'd1;
    if (state_q != S_SEND || wa_ready || drop) stall_d = 16'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= 16'd0;
      to_q    <= 1'b0;
    end else begin
      stall_q <= stall_d;
      if (drop) to_q <= 1'b1;
    end
  end

  assign to_err = to_q;
`else
  assign drop   = 1'b0;
  // Always 0: the timeout limit only matters when the stall counter is built.
  assign to_err = (TIMEOUT_CYC < 0);
`endif

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + LVL_W'(1);
      2'b01:   count_d = count_q - LVL_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (push || count_q != '0) state_d = S_SEND;
      S_SEND: if (count_d == '0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (push) begin
        mem_q[wr_ptr_q] <= {xa_addr, xa_data_wr};
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (xa_wr_s && full) ovf_q <= 1'b1;
    end
  end

  // Non-blocking update gives a same-edge read the pre-write shadow value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
      rd_vld_q  <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) shadow_q[i] <= '0;
    end else begin
      rd_vld_q <= xa_rd_s;
      if (xa_rd_s) rd_data_q <= shadow_q[idx];
      if (push) shadow_q[idx] <= xa_data_wr;
    end
  end

  assign xa_data_rd = rd_data_q;
  assign xa_rd_vld  = rd_vld_q;
  assign xa_busy    = full;
  assign {wa_addr, wa_data_wr} = mem_q[rd_ptr_q];
  assign wa_wr_s    = (state_q == S_SEND);
  assign fifo_level = count_q;
  assign ovf_err    = ovf_q;
  assign wa_state_o = state_q;

endmodule

// File: tb/tb_sif_wa_bridge.sv
// Self-checking bench for sif_wa_bridge; WA transfers are checked against an expected queue.
`timescale 1ns/1ps
module tb_sif_wa_bridge;

`ifdef SIF_WA_TIMEOUT_EN
  localparam int TO_CYC = 8;
`else
  localparam int TO_CYC = 64;
`endif

  logic        clk, rst;
  logic [15:0] xa_addr, xa_data_wr, xa_data_rd, wa_addr, wa_data_wr;
  logic        xa_wr_s, xa_rd_s, xa_rd_vld, xa_busy, wa_wr_s, wa_ready;
  logic [2:0]  fifo_level;
  logic        ovf_err, to_err, wa_state_o;

  logic [31:0] exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  sif_wa_bridge #(.ADDR_W(16), .DATA_W(16), .FIFO_DEPTH(4), .NUM_REGS(16), .TIMEOUT_CYC(TO_CYC)) dut (
    .clk(clk), .rst(rst), .xa_addr(xa_addr), .xa_data_wr(xa_data_wr), .xa_wr_s(xa_wr_s),
    .xa_rd_s(xa_rd_s), .xa_data_rd(xa_data_rd), .xa_rd_vld(xa_rd_vld), .xa_busy(xa_busy),
    .wa_addr(wa_addr), .wa_data_wr(wa_data_wr), .wa_wr_s(wa_wr_s), .wa_ready(wa_ready),
    .fifo_level(fifo_level), .ovf_err(ovf_err), .to_err(to_err), .wa_state_o(wa_state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard: every WA transfer (seen before its edge) must match the queue head
  always @(negedge clk) begin
    if (!rst && wa_wr_s && wa_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL wa_xfer_unexpected: got %h/%h, expected no transfer", wa_addr, wa_data_wr);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if ({wa_addr, wa_data_wr} !== e) begin
          n_err++;
          $display("FAIL wa_xfer: got %h/%h, expected %h/%h", wa_addr, wa_data_wr, e[31:16], e[15:0]);
        end
      end
    end
  end

  // driver: one XA write cycle; caller states whether the model expects it accepted
  task automatic wr_cycle(input logic [15:0] a, input logic [15:0] d, input bit accept);
    xa_wr_s = 1'b1; xa_addr = a; xa_data_wr = d;
    if (accept) exp_q.push_back({a, d});
    @(posedge clk); #1;
    xa_wr_s = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++; if (fifo_level !== 3'd0) begin n_err++; $display("FAIL rst_level: got %0d, expected 0", fifo_level); end
    n_cmp++; if ({wa_wr_s, xa_busy, ovf_err, to_err, xa_rd_vld} !== 5'b0) begin n_err++; $display("FAIL rst_flags: got %b, expected 00000", {wa_wr_s, xa_busy, ovf_err, to_err, xa_rd_vld}); end
    n_cmp++; if ({wa_addr, wa_data_wr, xa_data_rd} !== 48'h0) begin n_err++; $display("FAIL rst_data: got %h, expected 0", {wa_addr, wa_data_wr, xa_data_rd}); end
    // reset mid-traffic with 3 entries queued
    wa_ready = 1'b0;
    for (int i = 0; i < 3; i++) wr_cycle(16'h0100 + 16'(i), 16'h7000 + 16'(i), 1'b1);
    n_cmp++; if (fifo_level !== 3'd3) begin n_err++; $display("FAIL pre_rst_level: got %0d, expected 3", fifo_level); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    n_cmp++; if (fifo_level !== 3'd0) begin n_err++; $display("FAIL mid_rst_level: got %0d, expected 0", fifo_level); end
    n_cmp++; if ({wa_wr_s, xa_busy, ovf_err, wa_addr, wa_data_wr} !== 35'h0) begin n_err++; $display("FAIL mid_rst_outputs: got %h, expected 0", {wa_wr_s, xa_busy, ovf_err, wa_addr, wa_data_wr}); end
  endtask

  task automatic test_single();
    wa_ready = 1'b1;
    wr_cycle(16'h0005, 16'hA5A5, 1'b1);
    n_cmp++; if (wa_wr_s !== 1'b1 || wa_state_o !== 1'b1) begin n_err++; $display("FAIL single_valid: got wr_s=%b state=%b, expected 1/1", wa_wr_s, wa_state_o); end
    n_cmp++; if ({wa_addr, wa_data_wr} !== 32'h0005_A5A5) begin n_err++; $display("FAIL single_data: got %h/%h, expected 0005/a5a5", wa_addr, wa_data_wr); end
    n_cmp++; if (fifo_level !== 3'd1) begin n_err++; $display("FAIL single_level1: got %0d, expected 1", fifo_level); end
    @(posedge clk); #1;
    n_cmp++; if (fifo_level !== 3'd0 || wa_wr_s !== 1'b0) begin n_err++; $display("FAIL single_drain: got level=%0d wr_s=%b, expected 0/0", fifo_level, wa_wr_s); end
  endtask

  task automatic test_overflow();
    wa_ready = 1'b0;
    for (int i = 0; i < 4; i++) wr_cycle(16'h0200 + 16'(i), 16'hC000 + 16'(i), 1'b1);
    n_cmp++; if (fifo_level !== 3'd4 || xa_busy !== 1'b1 || ovf_err !== 1'b0) begin n_err++; $display("FAIL full: got level=%0d busy=%b ovf=%b, expected 4/1/0", fifo_level, xa_busy, ovf_err); end
    wr_cycle(16'h0299, 16'hDEAD, 1'b0);
    n_cmp++; if (fifo_level !== 3'd4 || ovf_err !== 1'b1) begin n_err++; $display("FAIL overflow: got level=%0d ovf=%b, expected 4/1", fifo_level, ovf_err); end
    wa_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++; if (wa_wr_s !== 1'b1) begin n_err++; $display("FAIL b2b_valid[%0d]: got %b, expected 1", i, wa_wr_s); end
      @(posedge clk); #1;
      n_cmp++; if (fifo_level !== 3'(3 - i)) begin n_err++; $display("FAIL drain_level[%0d]: got %0d, expected %0d", i, fifo_level, 3 - i); end
    end
    n_cmp++; if (wa_wr_s !== 1'b0 || ovf_err !== 1'b1) begin n_err++; $display("FAIL drain_end: got wr_s=%b ovf=%b, expected 0/1", wa_wr_s, ovf_err); end
  endtask

  task automatic test_shadow();
    wa_ready = 1'b1;
    wr_cycle(16'h0003, 16'h1234, 1'b1);
    xa_wr_s = 1'b1; xa_addr = 16'h0003; xa_data_wr = 16'h5678; xa_rd_s = 1'b1;
    exp_q.push_back({16'h0003, 16'h5678});
    @(posedge clk); #1;
    xa_wr_s = 1'b0;
    n_cmp++; if (xa_rd_vld !== 1'b1 || xa_data_rd !== 16'h1234) begin n_err++; $display("FAIL rd_pre_write: got vld=%b %h, expected 1/1234", xa_rd_vld, xa_data_rd); end
    @(posedge clk); #1;
    n_cmp++; if (xa_rd_vld !== 1'b1 || xa_data_rd !== 16'h5678) begin n_err++; $display("FAIL rd_post_write: got vld=%b %h, expected 1/5678", xa_rd_vld, xa_data_rd); end
    xa_addr = 16'h0013;
    @(posedge clk); #1;
    n_cmp++; if (xa_data_rd !== 16'h5678) begin n_err++; $display("FAIL rd_alias: got %h, expected 5678", xa_data_rd); end
    xa_rd_s = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (xa_rd_vld !== 1'b0) begin n_err++; $display("FAIL rd_vld_drop: got %b, expected 0", xa_rd_vld); end
    n_cmp++; if (fifo_level !== 3'd0) begin n_err++; $display("FAIL shadow_drain: got %0d, expected 0", fifo_level); end
  endtask

  task automatic test_stall();
    wa_ready = 1'b0;
    wr_cycle(16'h00C0, 16'hBEEF, 1'b1);
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if (wa_wr_s !== 1'b1 || {wa_addr, wa_data_wr} !== 32'h00C0_BEEF || fifo_level !== 3'd1) begin
        n_err++; $display("FAIL stall_hold[%0d]: got wr_s=%b %h/%h level=%0d, expected 1 00c0/beef 1", i, wa_wr_s, wa_addr, wa_data_wr, fifo_level);
      end
      @(posedge clk); #1;
    end
    wa_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (fifo_level !== 3'd0 || wa_wr_s !== 1'b0 || exp_q.size() != 0) begin n_err++; $display("FAIL stall_release: got level=%0d wr_s=%b pending=%0d, expected 0/0/0", fifo_level, wa_wr_s, exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] a, d;
    wa_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a = 16'($urandom_range(0, 16'hFFFF));
      d = 16'($urandom_range(0, 16'hFFFF));
      wr_cycle(a, d, 1'b1);
      n_cmp++; if (fifo_level !== 3'd1 || {wa_addr, wa_data_wr} !== {a, d}) begin n_err++; $display("FAIL b2b_stream[%0d]: got level=%0d %h/%h, expected 1 %h/%h", i, fifo_level, wa_addr, wa_data_wr, a, d); end
    end
    @(posedge clk); #1;
    n_cmp++; if (fifo_level !== 3'd0 || exp_q.size() != 0) begin n_err++; $display("FAIL b2b_end: got level=%0d pending=%0d, expected 0/0", fifo_level, exp_q.size()); end
  endtask

  task automatic test_timeout();
    wa_ready = 1'b0;
`ifdef SIF_WA_TIMEOUT_EN
    wr_cycle(16'h0A01, 16'h1111, 1'b1);
    wr_cycle(16'h0A02, 16'h2222, 1'b1);
    repeat (6) @(posedge clk);
    #1;
    n_cmp++; if (to_err !== 1'b0 || fifo_level !== 3'd2 || wa_addr !== 16'h0A01) begin n_err++; $display("FAIL to_before: got to=%b level=%0d addr=%h, expected 0/2/0a01", to_err, fifo_level, wa_addr); end
    @(posedge clk); #1;
    void'(exp_q.pop_front());
    n_cmp++; if (to_err !== 1'b1 || fifo_level !== 3'd1 || wa_wr_s !== 1'b1 || {wa_addr, wa_data_wr} !== 32'h0A02_2222) begin n_err++; $display("FAIL to_drop: got to=%b level=%0d %h/%h, expected 1/1 0a02/2222", to_err, fifo_level, wa_addr, wa_data_wr); end
    wa_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (fifo_level !== 3'd0) begin n_err++; $display("FAIL to_drain: got %0d, expected 0", fifo_level); end
`else
    wr_cycle(16'h0A01, 16'h1111, 1'b1);
    repeat (80) @(posedge clk);
    #1;
    n_cmp++; if (to_err !== 1'b0 || fifo_level !== 3'd1 || wa_addr !== 16'h0A01) begin n_err++; $display("FAIL no_timeout: got to=%b level=%0d addr=%h, expected 0/1/0a01", to_err, fifo_level, wa_addr); end
    wa_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (fifo_level !== 3'd0) begin n_err++; $display("FAIL no_timeout_drain: got %0d, expected 0", fifo_level); end
`endif
  endtask

  initial begin
    rst = 1'b1; xa_addr = '0; xa_data_wr = '0; xa_wr_s = 1'b0; xa_rd_s = 1'b0; wa_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_single();
    test_overflow();
    test_shadow();
    test_stall();
    test_back_to_back();
    test_timeout();
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL leftover: got %0d pending, expected 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
